// File: rtl/note_sequencer_if.sv
// Note sequencer bus: control strobes, note-table lookup and player outputs.
// The slave modport is the sequencer; the master modport is whatever drives
// start/stop/tick and supplies the note table.
interface note_sequencer_if #(
    parameter int p_nnotes       = 8,
    parameter int p_period_nbits = 8,
    parameter int p_dur_nbits    = 8
);
    localparam int IDX_W = $clog2(p_nnotes);

    logic                      start;
    logic                      stop;
    logic                      tick;
    logic [IDX_W-1:0]          rom_idx;
    logic [p_period_nbits-1:0] rom_period;
    logic [p_dur_nbits-1:0]    rom_dur;
    logic [p_period_nbits-1:0] player_period;
    logic                      player_en;
    logic                      busy;
    logic                      done;

    modport slave (
        input  start, stop, tick, rom_period, rom_dur,
        output rom_idx, player_period, player_en, busy, done
    );

    modport master (
        output start, stop, tick, rom_period, rom_dur,
        input  rom_idx, player_period, player_en, busy, done
    );
endinterface

// File: rtl/note_sequencer.sv
// Note sequencer: walks a combinational note table from index 0, feeds each
// note's half-period to the note player and times its duration in ticks.
// A zero duration marks end of song; a zero period is a rest (player off).
module note_sequencer #(
    parameter int p_nnotes       = 8,
    parameter int p_period_nbits = 8,
    parameter int p_dur_nbits    = 8
) (
    input  logic               clk,
    input  logic               rst,
    note_sequencer_if.slave    bus
);
    localparam int IDX_W = $clog2(p_nnotes);
    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(p_nnotes - 1);
    localparam logic [p_dur_nbits-1:0] DUR_ONE  = p_dur_nbits'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PLAY,
        ST_FINISH
    } state_t;

    state_t                    state_q;
    logic [IDX_W-1:0]          idx_q;
    logic [p_period_nbits-1:0] period_q;
    logic [p_dur_nbits-1:0]    dur_q;
    logic                      en_q;
    logic                      busy_q;
    logic                      done_q;

    // Sequencer FSM; every player-facing output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            period_q <= '0;
            dur_q    <= '0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (state_q != ST_IDLE && bus.stop) begin
            // Abort: back to idle without a completion pulse.
            state_q <= ST_IDLE;
            idx_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start && !bus.stop) begin
                        state_q <= ST_FETCH;
                        busy_q  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (bus.rom_dur == '0) begin
                        // End-of-song marker: keep the last period untouched.
                        state_q <= ST_FINISH;
                        done_q  <= 1'b1;
                    end else begin
                        period_q <= bus.rom_period;
                        dur_q    <= bus.rom_dur;
                        en_q     <= (bus.rom_period != '0);
                        state_q  <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (bus.tick) begin
                        dur_q <= dur_q - DUR_ONE;
                        if (dur_q == DUR_ONE) begin
                            en_q <= 1'b0;
                            if (idx_q == LAST_IDX) begin
                                // Table is full: the last slot always ends the song.
                                state_q <= ST_FINISH;
                                done_q  <= 1'b1;
                            end else begin
                                idx_q   <= idx_q + IDX_W'(1);
                                state_q <= ST_FETCH;
                            end
                        end
                    end
                end
                ST_FINISH: begin
                    done_q  <= 1'b0;
                    idx_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    idx_q   <= '0;
                    en_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rom_idx       = idx_q;
    assign bus.player_period = period_q;
    assign bus.player_en     = en_q;
    assign bus.busy          = busy_q;
    // A stop landing in FINISH must suppress the pulse in that same cycle.
    assign bus.done          = done_q & ~bus.stop;
endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: stimulus pushes the expected output
// changes (with the cycle they must appear in); a monitor pops one entry on
// every observed change of the output vector and compares.
module tb_note_sequencer;
    logic clk;
    logic rst;

    note_sequencer_if #(.p_nnotes(8), .p_period_nbits(8), .p_dur_nbits(8)) bus ();

    note_sequencer #(.p_nnotes(8), .p_period_nbits(8), .p_dur_nbits(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         cyc;
        logic [2:0] idx;
        logic [7:0] per;
        logic       en;
        logic       busy;
        logic       done;
    } rec_t;

    rec_t       exp_q[$];
    logic [7:0] tbl_per[8];
    logic [7:0] tbl_dur[8];
    int         cyc = 0;
    int         base = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic [13:0] prev_vec = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Combinational note table.
    always_comb begin
        bus.rom_period = tbl_per[bus.rom_idx];
        bus.rom_dur    = tbl_dur[bus.rom_idx];
    end

    // Monitor: one scoreboard entry per change of the observable outputs.
    always @(negedge clk) begin
        logic [13:0] cur;
        rec_t        e;
        cur = {bus.rom_idx, bus.player_period, bus.player_en, bus.busy, bus.done};
        if (!rst && cur !== prev_vec) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_change cyc=%0d got idx=%0d per=%0d en=%0b busy=%0b done=%0b, required no change",
                         cyc, cur[13:11], cur[10:3], cur[2], cur[1], cur[0]);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || cur !== {e.idx, e.per, e.en, e.busy, e.done}) begin
                    n_fail++;
                    $display("FAIL output_change got cyc=%0d idx=%0d per=%0d en=%0b busy=%0b done=%0b, required cyc=%0d idx=%0d per=%0d en=%0b busy=%0b done=%0b",
                             cyc, cur[13:11], cur[10:3], cur[2], cur[1], cur[0],
                             e.cyc, e.idx, e.per, e.en, e.busy, e.done);
                end else begin
                    $display("ok cyc=%0d idx=%0d per=%0d en=%0b busy=%0b done=%0b",
                             cyc, cur[13:11], cur[10:3], cur[2], cur[1], cur[0]);
                end
            end
        end
        prev_vec = rst ? 14'd0 : cur;
    end

    task automatic step(input logic s, input logic p, input logic t);
        bus.start = s;
        bus.stop  = p;
        bus.tick  = t;
        @(posedge clk);
        #1;
    endtask

    task automatic exp_rec(input int rel, input int idx, input int per,
                           input logic en, input logic busy, input logic done);
        rec_t r;
        r.cyc  = base + rel;
        r.idx  = 3'(idx);
        r.per  = 8'(per);
        r.en   = en;
        r.busy = busy;
        r.done = done;
        exp_q.push_back(r);
    endtask

    task automatic load_table_a();
        for (int i = 0; i < 8; i++) begin
            tbl_per[i] = 8'd0;
            tbl_dur[i] = 8'd0;
        end
        tbl_per[0] = 8'd10; tbl_dur[0] = 8'd2;
        tbl_per[1] = 8'd20; tbl_dur[1] = 8'd1;
        tbl_per[2] = 8'd99; tbl_dur[2] = 8'd0;
    endtask

    task automatic load_table_full();
        for (int i = 0; i < 8; i++) begin
            tbl_per[i] = 8'(i + 1);
            tbl_dur[i] = 8'd1;
        end
    endtask

    // Expected changes for table A with ticks every 4 cycles, prior period p0.
    task automatic expect_table_a(input int p0);
        exp_rec(1,  0, p0, 0, 1, 0);
        exp_rec(2,  0, 10, 1, 1, 0);
        exp_rec(9,  1, 10, 0, 1, 0);
        exp_rec(10, 1, 20, 1, 1, 0);
        exp_rec(13, 2, 20, 0, 1, 0);
        exp_rec(14, 2, 20, 0, 1, 1);
        exp_rec(15, 0, 20, 0, 0, 0);
    endtask

    // Watchdog: the bench must never hang.
    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d, required completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.tick  = 1'b0;
        load_table_a();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, 0, 0);

        // Two notes then end marker, ticks every 4 cycles.
        base = cyc;
        expect_table_a(0);
        for (int r = 0; r < 20; r++) step(r == 0, 0, (r % 4 == 0) && (r > 0));

        // Rest note followed by a sounding note.
        for (int i = 0; i < 8; i++) begin tbl_per[i] = 8'd0; tbl_dur[i] = 8'd0; end
        tbl_per[0] = 8'd0; tbl_dur[0] = 8'd3;
        tbl_per[1] = 8'd5; tbl_dur[1] = 8'd1;
        tbl_per[2] = 8'd77; tbl_dur[2] = 8'd0;
        base = cyc;
        exp_rec(1,  0, 20, 0, 1, 0);
        exp_rec(2,  0, 0,  0, 1, 0);
        exp_rec(7,  1, 0,  0, 1, 0);
        exp_rec(8,  1, 5,  1, 1, 0);
        exp_rec(9,  2, 5,  0, 1, 0);
        exp_rec(10, 2, 5,  0, 1, 1);
        exp_rec(11, 0, 5,  0, 0, 0);
        for (int r = 0; r < 14; r++) step(r == 0, 0, (r % 2 == 0) && (r > 0));

        // Full 8-note song, tick every cycle (also in FETCH), start held high.
        load_table_full();
        base = cyc;
        exp_rec(1, 0, 5, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) exp_rec(1 + 2 * i, i, i, 0, 1, 0);
            exp_rec(2 + 2 * i, i, i + 1, 1, 1, 0);
        end
        exp_rec(17, 7, 8, 0, 1, 1);
        exp_rec(18, 0, 8, 0, 0, 0);
        for (int r = 0; r < 22; r++) step(r <= 17, 0, 1);

        // Stop while playing idx 3, then start+stop together in IDLE.
        base = cyc;
        exp_rec(1, 0, 8, 0, 1, 0);
        exp_rec(2, 0, 1, 1, 1, 0);
        exp_rec(3, 1, 1, 0, 1, 0);
        exp_rec(4, 1, 2, 1, 1, 0);
        exp_rec(5, 2, 2, 0, 1, 0);
        exp_rec(6, 2, 3, 1, 1, 0);
        exp_rec(7, 3, 3, 0, 1, 0);
        exp_rec(8, 3, 4, 1, 1, 0);
        exp_rec(9, 0, 4, 0, 0, 0);
        for (int r = 0; r < 17; r++) step((r == 0) || (r == 12), (r == 8) || (r == 12), 1);

        // End marker at idx 0: done two cycles after start.
        tbl_per[0] = 8'd7;
        tbl_dur[0] = 8'd0;
        base = cyc;
        exp_rec(1, 0, 4, 0, 1, 0);
        exp_rec(2, 0, 4, 0, 1, 1);
        exp_rec(3, 0, 4, 0, 0, 0);
        for (int r = 0; r < 6; r++) step(r == 0, 0, 0);

        // Stop during FINISH: back to idle with no done pulse.
        base = cyc;
        exp_rec(1, 0, 4, 0, 1, 0);
        exp_rec(3, 0, 4, 0, 0, 0);
        for (int r = 0; r < 6; r++) step(r == 0, r == 2, 0);

        // Reset pulse mid-PLAY, then a full replay from idx 0.
        load_table_a();
        base = cyc;
        exp_rec(1, 0, 4,  0, 1, 0);
        exp_rec(2, 0, 10, 1, 1, 0);
        exp_rec(3, 0, 0,  0, 0, 0);
        for (int r = 0; r < 3; r++) step(r == 0, 0, 0);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.tick  = 1'b0;
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        base = cyc;
        expect_table_a(0);
        for (int r = 0; r < 20; r++) step(r == 0, 0, (r % 4 == 0) && (r > 0));

        repeat (2) step(0, 0, 0);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got %0d pending entries, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
